// File: rtl/display_pkg.sv
// Shared constants and helpers for the seven-segment scheduler.
// Mode type and anode pattern generation.
package display_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } mode_t;

  function automatic logic [3:0] an_onehot(
    input logic [1:0] pos
  );
    return AN_OFF ^ (4'b0001 << pos);
  endfunction

endpackage

// File: rtl/display_scheduler_debounce.sv
// Two-flop synchronizer plus stability counter for one raw button.
// Emits a one-cycle pulse on each accepted press.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Synchronize, then flip the level once it disagrees long enough
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync       <= '0;
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync       <= {sync[0], btn_raw};
      rise_pulse <= 1'b0;
      if (sync[1] != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES)) begin
          level      <= sync[1];
          rise_pulse <= sync[1];
          cnt        <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Scans the 4-digit display over a selected half of one source word.
// Selection is button-stepped or auto-rotated on a dwell timer.
module display_scheduler
  import display_pkg::*;
#(
  parameter int NUM_SRC         = 4,
  parameter int SCAN_DIV        = 65536,
  parameter int DWELL_CYCLES    = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC*32-1:0]      src_data,
  input  logic                       auto_en,
  input  logic                       btn_next,
  input  logic                       btn_half,
  output logic [3:0]                 an,
  output logic [3:0]                 digit,
  output logic                       dp,
  output logic [$clog2(NUM_SRC)-1:0] src_sel,
  output logic                       half_sel
);

  localparam int SW  = $clog2(NUM_SRC);
  localparam int SCW = $clog2(SCAN_DIV);
  localparam int DWW = $clog2(DWELL_CYCLES);

  logic [SCW-1:0] scan_cnt;
  logic [1:0]     pos;
  logic [15:0]    snapshot;
  logic [DWW-1:0] dwell;
  mode_t          state;

  logic           next_lvl;
  logic           next_pulse;
  logic           half_lvl;
  logic           half_pulse;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_next (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_next),
    .level     (next_lvl),
    .rise_pulse(next_pulse)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_half (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_half),
    .level     (half_lvl),
    .rise_pulse(half_pulse)
  );

  logic        scan_tick;
  logic        frame;
  logic [1:0]  pos_nxt;
  logic [31:0] src_word;
  logic [15:0] snap_nxt;

  assign scan_tick = scan_cnt == SCW'(SCAN_DIV - 1);
  assign frame     = scan_tick && (pos == 2'd3);
  assign pos_nxt   = pos + 2'd1;
  assign src_word  = src_data[32*int'(src_sel) +: 32];
  assign snap_nxt  = !frame   ? snapshot :
                     half_sel ? src_word[31:16] :
                                src_word[15:0];

  // Digit scan; snapshot reloads only at the frame boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      pos      <= '0;
      snapshot <= '0;
      an       <= an_onehot(2'd0);
      digit    <= '0;
      dp       <= 1'b1;
    end else if (scan_tick) begin
      scan_cnt <= '0;
      pos      <= pos_nxt;
      snapshot <= snap_nxt;
      an       <= an_onehot(pos_nxt);
      digit    <= snap_nxt[{pos_nxt, 2'b00} +: 4];
      dp       <= ~((pos_nxt == 2'd3) & half_sel);
    end else begin
      scan_cnt <= scan_cnt + SCW'(1);
    end
  end

  logic [SW-1:0] src_inc;
  logic          expiry;
  logic          mode_chg;

  assign src_inc  = (src_sel == SW'(NUM_SRC - 1)) ?
                    '0 : src_sel + SW'(1);
  assign expiry   = dwell == DWW'(DWELL_CYCLES - 1);
  assign mode_chg = (state == AUTO) != auto_en;

  // Mode FSM and source/half selection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= MANUAL;
      dwell    <= '0;
      src_sel  <= '0;
      half_sel <= 1'b0;
    end else begin
      state <= auto_en ? AUTO : MANUAL;
      unique case (state)
        MANUAL: begin
          dwell <= '0;
          if (next_pulse) src_sel  <= src_inc;
          if (half_pulse) half_sel <= ~half_sel;
        end
        AUTO: begin
          if (next_pulse) begin
            src_sel  <= src_inc;
            half_sel <= 1'b0;
            dwell    <= '0;
          end else if (half_pulse) begin
            half_sel <= ~half_sel;
            dwell    <= '0;
          end else if (expiry) begin
            half_sel <= ~half_sel;
            if (half_sel) src_sel <= src_inc;
            dwell <= '0;
          end else begin
            dwell <= dwell + DWW'(1);
          end
        end
        default: dwell <= '0;
      endcase
      if (mode_chg) dwell <= '0;
    end
  end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Sequences the Basys 4-digit seven-segment display over several 32-bit pipeline sources. It contains:
- the digit-scan counter;
- the source/half selection state machine, either auto-rotating or button-stepped;
- button debouncing.

Per digit it emits a registered anode pattern and hex nibble; the existing hex-to-segment decode consumes `digit`. Sits between the core's register taps and the board pins.

## Interface
- `NUM_SRC`, 4: number of 32-bit sources, ≥2.
- `SCAN_DIV`, 65536: clk cycles per digit slot, ≥2.
- `DWELL_CYCLES`, 50_000_000: clk cycles per auto-rotation step, ≥2.
- `DEBOUNCE_CYCLES`, 1_000_000: stable cycles required to accept a button level, ≥1.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: reset; asynchronous, active-high.
- `src_data` in `NUM_SRC*32`: source k at bits [32k+31:32k].
- `auto_en` in 1: level; 1 = AUTO mode, 0 = MANUAL.
- `btn_next` in 1: raw asynchronous button, advance source.
- `btn_half` in 1: raw asynchronous button, toggle displayed half.
- `an` out 4: anodes, active-low, one-hot-low.
- `digit` out 4: nibble for the active anode.
- `dp` out 1: decimal point, active-low.
- `src_sel` out `$clog2(NUM_SRC)`: currently selected source.
- `half_sel` out 1: 0 = bits [15:0], 1 = bits [31:16].

## Operation
- **Reset values:** `an`=4'b1110, `digit`=0, `dp`=1, `src_sel`=0, `half_sel`=0. All counters and the snapshot are 0, state=MANUAL.
- **Scan:**
  - `scan_cnt` counts 0..`SCAN_DIV`-1. At terminal count a scan tick fires, `scan_cnt` wraps to 0 and `pos` advances 0→1→2→3→0.
  - `an`=~(1<<pos).
  - `digit`=snapshot[4*pos+3:4*pos].
  - `dp`=0 only when pos=3 and `half_sel`=1.
- **Snapshot:**
  - The 16-bit snapshot = selected half of `src_data[src_sel]`.
  - It loads only on the scan tick where pos 3→0. This is a tear-free frame boundary.
  - Selection changes therefore reach the pins within ≤4·`SCAN_DIV` cycles.
- **State machine:**
  - MANUAL→AUTO when `auto_en`=1.
  - AUTO→MANUAL when `auto_en`=0.
  - Both transitions take effect the cycle after the level is sampled. The dwell counter clears on either transition.
- **MANUAL:**
  - `next_pulse` sets `src_sel`←(`src_sel`+1) mod `NUM_SRC`; `half_sel` is unchanged.
  - `half_pulse` toggles `half_sel`.
  - Simultaneous pulses: both apply.
- **AUTO:**
  - The dwell counter counts to `DWELL_CYCLES`-1, then steps the pair in the order (0,lo),(0,hi),(1,lo),…,(`NUM_SRC`-1,hi),(0,lo).
  - `next_pulse` advances `src_sel`, sets `half_sel`=0 and restarts the dwell counter.
  - Dwell expiry coincident with `next_pulse`: a single `next_pulse` advance.
  - `half_pulse` toggles `half_sel` and restarts the dwell counter.
- **Debounce, per button:**
  - 2-flop synchronizer.
  - A counter increments while the synchronized value ≠ the debounced level, and clears otherwise. At `DEBOUNCE_CYCLES` the debounced level flips.
  - A one-cycle pulse is emitted on the 0→1 flip only. Holding the button produces one pulse.
- **Reset mid-operation:** all state returns to reset values immediately (async). The display restarts at pos 0 with snapshot 0.

## Timing
- Button raw 1 sampled at edge t:
  - synchronized value is 1 at t+2;
  - debounced level and pulse at t+2+`DEBOUNCE_CYCLES`;
  - `src_sel`/`half_sel` update at t+3+`DEBOUNCE_CYCLES`.
- A bounce shorter than `DEBOUNCE_CYCLES` produces no pulse.
- `an`, `digit` and `dp` are registered and change together on the scan-tick edge. There is no cycle where two anodes are low.
- `src_sel`/`half_sel` are registered. On an AUTO dwell expiry they update on the edge where the counter wraps.
- A `src_data` change reaches the pins at the next frame boundary, not earlier.

## Structure
- **Package `display_pkg`:**
  - `NUM_DIGITS`=4;
  - `AN_OFF`=4'b1111;
  - mode enum {MANUAL, AUTO};
  - a function for the one-hot-low anode pattern from pos.
- **Sub-module `button_debounce`:** parameter `DEBOUNCE_CYCLES`; ports `clk`, `reset`, `btn_raw` → `level`, `rise_pulse`. Instantiated twice.
- Scan, snapshot and mode FSM stay in the top module.

## Test plan
Bench parameters: `SCAN_DIV`=4, `DWELL_CYCLES`=20, `DEBOUNCE_CYCLES`=3, `NUM_SRC`=4.

1. **Reset and scan:** src0=32'h1234_5678, auto_en=0, release reset → `an` cycles 1110,1101,1011,0111 every 4 cycles. After the first frame boundary `digit` reads 8,7,6,5 and `dp`=1 throughout.
2. **Half toggle:** btn_half held 10 cycles → `half_sel`=1 exactly 6 cycles after first sampling. From the next frame `digit` reads 4,3,2,1 and `dp`=0 on pos 3.
3. **Bounce rejection:** btn_next pulses 0-1-0-1 in 2-cycle bursts, then held 1 → exactly one `src_sel` increment, 0→1.
4. **Wrap:** in MANUAL, press btn_next 4 times from `src_sel`=3 → sequence 0,1,2,3 after the presses; no out-of-range value.
5. **AUTO rotation:** auto_en=1 for 200 cycles → pairs step every 20 cycles (0,lo),(0,hi),(1,lo),…, wrapping after (3,hi). A btn_next pulse landing on a dwell expiry yields a single advance.
6. **Async reset mid-frame:** assert reset at pos=2 in AUTO → all outputs at reset values without waiting for a `clk` edge. After release, scan restarts at `an`=1110.
